idma_obi_read_beat_gen: RTL and testbench
=========================================

IDMA_OBI_READ_BEAT_GEN -- requirements
Module: idma_obi_read_beat_gen

Interface
REQ-001 Param AddrWidth, default 32, address and length width.
REQ-002 Param StrbWidth, default 4, bytes per OBI beat; power of two, at least 2; OW = log2(StrbWidth).
REQ-003 Param DepthDp, default 4, depth of the datapath-descriptor FIFO; power of two, at least 2.
REQ-004 clk_i  in  1  sole clock; all logic rising-edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  1D transfer handshake.
REQ-007 req_src_addr_i  in  AddrWidth  byte source address.
REQ-008 req_length_i  in  AddrWidth  byte count.
REQ-009 req_dst_offset_i  in  OW  destination byte offset.
REQ-010 meta_valid_o / meta_ready_i  out/in  1/1  OBI read-beat request; meta_ready_i is the OBI gnt.
REQ-011 meta_addr_o  out  AddrWidth  beat address, aligned to StrbWidth.
REQ-012 dp_valid_o / dp_ready_i  out/in  1/1  per-beat datapath descriptor handshake.
REQ-013 dp_offset_o, dp_tailer_o, dp_shift_o  out  OW each  first-valid byte, end byte (0 = full beat), realignment shift.
REQ-014 busy_o  out  1  transfer in progress or descriptors pending.

Function
REQ-015 FSM has two states: IDLE and ISSUE.
REQ-016 req_ready_o SHALL be 1 in IDLE and 0 in ISSUE.
REQ-017 On a req handshake in IDLE, the block SHALL register the transfer fields.
REQ-018 Beat count SHALL be ceil((src_addr[OW-1:0] + length) / StrbWidth), computed at AddrWidth+1 bits.
REQ-019 A transfer with length 0 SHALL be accepted, SHALL stay in IDLE and SHALL issue no beat.
REQ-020 A transfer with non-zero length SHALL move the FSM to ISSUE on the next cycle.
REQ-021 In ISSUE, meta_valid_o SHALL be 1 if and only if the descriptor FIFO is not full; in IDLE it SHALL be 0.
REQ-022 meta_addr_o SHALL be src_addr with the low OW bits cleared, plus beat_index * StrbWidth.
REQ-023 Address arithmetic SHALL wrap modulo 2^AddrWidth.
REQ-024 meta_addr_o SHALL be held stable while meta_valid_o=1 and meta_ready_i=0.
REQ-025 Each meta handshake SHALL push exactly one descriptor into the FIFO and increment beat_index.
REQ-026 On the handshake of the last beat, the FSM SHALL return to IDLE on the next cycle.
REQ-027 A new request MAY be accepted in that IDLE cycle while the FIFO still drains.
REQ-028 Descriptor offset SHALL be src_addr[OW-1:0] on the first beat and 0 otherwise.
REQ-029 Descriptor tailer SHALL be (src_addr[OW-1:0] + length) mod StrbWidth on the last beat and 0 otherwise.
REQ-030 A single-beat transfer SHALL carry both the first-beat offset and the last-beat tailer.
REQ-031 Descriptor shift SHALL be (src_addr[OW-1:0] - dst_offset) mod StrbWidth, constant for the whole transfer.
REQ-032 The FIFO SHALL be non-fall-through: a descriptor becomes visible at dp_* one cycle after its push.
REQ-033 dp_valid_o SHALL equal FIFO not empty, and dp_* SHALL present the FIFO head.
REQ-034 When full, the FIFO SHALL accept no push, even if a pop occurs in the same cycle.
REQ-035 When neither full nor empty, a simultaneous push and pop SHALL keep the fill count unchanged.
REQ-036 FIFO read and write pointers SHALL wrap modulo DepthDp.
REQ-037 busy_o SHALL be 1 when state is ISSUE or the FIFO is non-empty, and 0 otherwise.

Reset
REQ-038 Asserting rst_i SHALL immediately force IDLE, beat_index 0 and FIFO empty, including mid-transfer; pending beats are discarded.
REQ-039 During reset: req_ready_o=1, meta_valid_o=0, meta_addr_o=0, dp_valid_o=0, dp_offset_o=0, dp_tailer_o=0, dp_shift_o=0, busy_o=0.

Verification (StrbWidth=4, DepthDp=4)
REQ-040 Transfer src 0x1002, len 7, dst_off 1, all readies 1 -> 3 beats at 0x1000/0x1004/0x1008; (offset,tailer) = (2,0),(0,0),(0,1); shift 1 on every beat.
REQ-041 Transfer src 0x2001, len 2, dst_off 3 -> 1 beat at 0x2000; offset 1, tailer 3, shift 2.
REQ-042 Transfer len 0 -> req handshake occurs; meta_valid_o and dp_valid_o stay 0; busy_o stays 0.
REQ-043 Transfer src 0x0, len 32, dp_ready_i=0 -> exactly 4 meta handshakes, then meta_valid_o=0 with meta_addr_o=0x10 held; after dp_ready_i goes to 1, all 8 beats complete in address order.
REQ-044 Transfer src 0xFFFFFFFC, len 8 -> beats at 0xFFFFFFFC, then 0x00000000.
REQ-045 Assert rst_i after the 2nd beat of an 8-beat transfer -> outputs take REQ-039 values in the same cycle; after release, a new transfer runs correctly.

Source files
------------

// File: rtl/idma_obi_read_beat_gen.sv
// Splits a 1D byte transfer into StrbWidth-aligned OBI read beats and
// queues one datapath descriptor per beat for the realignment stage.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_*                    1D transfer request (src address, byte length, dst byte offset)
//   meta_valid_o/ready_i     OBI read-beat request (ready is the OBI gnt), address in meta_addr_o
//   dp_valid_o/ready_i       per-beat descriptor: first-valid byte, end byte, realignment shift
//   busy_o                   transfer in progress or descriptors still queued
module idma_obi_read_beat_gen #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned StrbWidth = 4,
    parameter int unsigned DepthDp   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_src_addr_i,
    input  logic [AddrWidth-1:0]         req_length_i,
    input  logic [$clog2(StrbWidth)-1:0] req_dst_offset_i,
    output logic                         meta_valid_o,
    input  logic                         meta_ready_i,
    output logic [AddrWidth-1:0]         meta_addr_o,
    output logic                         dp_valid_o,
    input  logic                         dp_ready_i,
    output logic [$clog2(StrbWidth)-1:0] dp_offset_o,
    output logic [$clog2(StrbWidth)-1:0] dp_tailer_o,
    output logic [$clog2(StrbWidth)-1:0] dp_shift_o,
    output logic                         busy_o
);

    localparam int unsigned OW = $clog2(StrbWidth);
    localparam int unsigned PW = $clog2(DepthDp);
    localparam int unsigned DW = 3 * OW;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth:0]   beats_left_q, beats_left_d;
    logic                 first_q, first_d;
    logic [OW-1:0]        offset_q, offset_d;
    logic [OW-1:0]        tailer_q, tailer_d;
    logic [OW-1:0]        shift_q, shift_d;

    logic [DW-1:0]        mem_q [DepthDp];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q, count_d;

    logic                 fifo_full, fifo_empty;
    logic                 req_hs, meta_hs, push, pop, last_beat;
    logic [AddrWidth:0]   span, beats;
    logic [DW-1:0]        push_data, head;

    assign fifo_full  = (count_q == (PW+1)'(DepthDp));
    assign fifo_empty = (count_q == '0);

    assign req_ready_o  = (state_q == StIdle);
    assign meta_valid_o = (state_q == StIssue) && !fifo_full;
    assign meta_addr_o  = addr_q;
    assign busy_o       = (state_q == StIssue) || !fifo_empty;

    assign req_hs    = req_valid_i && req_ready_o;
    assign meta_hs   = meta_valid_o && meta_ready_i;
    assign push      = meta_hs;
    assign pop       = dp_valid_o && dp_ready_i;
    assign last_beat = (beats_left_q == (AddrWidth+1)'(1));

    // Bytes covered from the aligned start; one extra bit so len near 2^AW cannot overflow.
    assign span  = {{(AddrWidth+1-OW){1'b0}}, req_src_addr_i[OW-1:0]} + {1'b0, req_length_i};
    assign beats = (span + (AddrWidth+1)'(StrbWidth - 1)) >> OW;

    assign push_data = {first_q ? offset_q : '0, last_beat ? tailer_q : '0, shift_q};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        first_d      = first_q;
        offset_d     = offset_q;
        tailer_d     = tailer_q;
        shift_d      = shift_q;
        case (state_q)
            StIdle: begin
                if (req_hs) begin
                    addr_d       = {req_src_addr_i[AddrWidth-1:OW], {OW{1'b0}}};
                    beats_left_d = beats;
                    first_d      = 1'b1;
                    offset_d     = req_src_addr_i[OW-1:0];
                    tailer_d     = span[OW-1:0];
                    shift_d      = req_src_addr_i[OW-1:0] - req_dst_offset_i;
                    // Zero-length transfers are consumed without issuing anything.
                    if (req_length_i != '0) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (meta_hs) begin
                    addr_d       = addr_q + AddrWidth'(StrbWidth);
                    beats_left_d = beats_left_q - (AddrWidth+1)'(1);
                    first_d      = 1'b0;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            beats_left_q <= '0;
            first_q      <= 1'b0;
            offset_q     <= '0;
            tailer_q     <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            first_q      <= first_d;
            offset_q     <= offset_d;
            tailer_q     <= tailer_d;
            shift_q      <= shift_d;
        end
    end

    // Descriptor FIFO: push is already blocked when full because meta_valid_o drops.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Outputs are zeroed while empty so stale storage never shows at dp_*.
    assign head        = mem_q[rd_ptr_q];
    assign dp_valid_o  = !fifo_empty;
    assign dp_offset_o = fifo_empty ? '0 : head[3*OW-1 -: OW];
    assign dp_tailer_o = fifo_empty ? '0 : head[2*OW-1 -: OW];
    assign dp_shift_o  = fifo_empty ? '0 : head[OW-1:0];

endmodule

// File: tb/tb_idma_obi_read_beat_gen.sv
module tb_idma_obi_read_beat_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned S  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_src = '0;
    logic [AW-1:0] req_len = '0;
    logic [1:0]    req_dst = '0;
    logic          meta_valid;
    logic          meta_ready = 1'b1;
    logic [AW-1:0] meta_addr;
    logic          dp_valid;
    logic          dp_ready = 1'b1;
    logic [1:0]    dp_offset, dp_tailer, dp_shift;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int meta_hs_cnt = 0;

    bit rand_mode    = 1'b0;
    bit f_meta_ready = 1'b1;
    bit f_dp_ready   = 1'b1;

    bit [31:0] exp_addr[$];
    bit [5:0]  exp_dp[$];

    bit        hold_prev = 1'b0;
    bit [31:0] hold_addr = '0;

    always #5 clk = ~clk;

    idma_obi_read_beat_gen #(
        .AddrWidth(AW),
        .StrbWidth(S),
        .DepthDp  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_src_addr_i  (req_src),
        .req_length_i    (req_len),
        .req_dst_offset_i(req_dst),
        .meta_valid_o    (meta_valid),
        .meta_ready_i    (meta_ready),
        .meta_addr_o     (meta_addr),
        .dp_valid_o      (dp_valid),
        .dp_ready_i      (dp_ready),
        .dp_offset_o     (dp_offset),
        .dp_tailer_o     (dp_tailer),
        .dp_shift_o      (dp_shift),
        .busy_o          (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expand one transfer into its beats with plain arithmetic.
    function automatic void model_push(input bit [31:0] s, input bit [31:0] l, input bit [1:0] d);
        longint unsigned off, total, nb, base, a;
        int unsigned o, t, sh;
        off   = longint'(s) % S;
        total = off + longint'(l);
        nb    = (total + S - 1) / S;
        base  = longint'(s) - off;
        sh    = int'((off + S - longint'(d)) % S);
        for (longint unsigned i = 0; i < nb; i++) begin
            a = (base + i * S) % 64'h1_0000_0000;
            o = (i == 0) ? int'(off) : 0;
            t = (i == nb - 1) ? int'(total % S) : 0;
            exp_addr.push_back(a[31:0]);
            exp_dp.push_back({o[1:0], t[1:0], sh[1:0]});
        end
    endfunction

    // Ready driver: changes only just after a rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            meta_ready = 1'($urandom_range(0, 1));
            dp_ready   = 1'($urandom_range(0, 1));
        end else begin
            meta_ready = f_meta_ready;
            dp_ready   = f_dp_ready;
        end
    end

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(meta_valid), 64'd1);
                check("hold_addr", 64'(meta_addr), 64'(hold_addr));
            end
            check("busy", 64'(busy), 64'(exp_dp.size() != 0));
            if (exp_addr.size() == 0) check("meta_spurious", 64'(meta_valid), 64'd0);
            if (exp_dp.size() == 0) check("dp_spurious", 64'(dp_valid), 64'd0);
            if (meta_valid && meta_ready) begin
                meta_hs_cnt++;
                if (exp_addr.size() != 0) check("meta_addr", 64'(meta_addr), 64'(exp_addr.pop_front()));
            end
            if (dp_valid && dp_ready && exp_dp.size() != 0) begin
                check("dp_desc", 64'({dp_offset, dp_tailer, dp_shift}), 64'(exp_dp.pop_front()));
            end
            hold_prev = meta_valid && !meta_ready;
            hold_addr = meta_addr;
        end
    end

    task automatic send(input bit [31:0] s, input bit [31:0] l, input bit [1:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        req_src   = s;
        req_len   = l;
        req_dst   = d;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("req_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(s, l, d);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_addr.size() != 0 || exp_dp.size() != 0 || busy) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("drain_addr", 64'(exp_addr.size()), 64'd0);
        check("drain_dp", 64'(exp_dp.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_meta_valid", 64'(meta_valid), 64'd0);
        check("rst_meta_addr", 64'(meta_addr), 64'd0);
        check("rst_dp_valid", 64'(dp_valid), 64'd0);
        check("rst_dp_offset", 64'(dp_offset), 64'd0);
        check("rst_dp_tailer", 64'(dp_tailer), 64'd0);
        check("rst_dp_shift", 64'(dp_shift), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int n;
        bit [31:0] s;

        #12;
        check_reset_outputs();
        @(posedge clk);
        #2 rst = 1'b0;

        // Three-beat transfer and single-beat transfer, full throughput.
        send(32'h0000_1002, 32'd7, 2'd1);
        drain();
        send(32'h0000_2001, 32'd2, 2'd3);
        drain();

        // Zero-length transfer: accepted, nothing issued.
        cnt0 = meta_hs_cnt;
        send(32'h0000_3000, 32'd0, 2'd2);
        repeat (5) begin
            @(negedge clk);
            check("zero_meta_valid", 64'(meta_valid), 64'd0);
            check("zero_dp_valid", 64'(dp_valid), 64'd0);
            check("zero_busy", 64'(busy), 64'd0);
        end
        check("zero_hs", 64'(meta_hs_cnt - cnt0), 64'd0);
        check("zero_req_ready", 64'(req_ready), 64'd1);

        // Backpressure: FIFO fills after four beats and the address holds.
        f_dp_ready = 1'b0;
        cnt0 = meta_hs_cnt;
        send(32'h0000_0000, 32'd32, 2'd0);
        repeat (12) @(negedge clk);
        check("full_hs", 64'(meta_hs_cnt - cnt0), 64'd4);
        check("full_meta_valid", 64'(meta_valid), 64'd0);
        check("full_meta_addr", 64'(meta_addr), 64'h10);
        check("full_dp_valid", 64'(dp_valid), 64'd1);
        f_dp_ready = 1'b1;
        drain();

        // Address wrap at the top of the address space.
        send(32'hFFFF_FFFC, 32'd8, 2'd0);
        drain();

        // Reset in the middle of an 8-beat transfer.
        cnt0 = meta_hs_cnt;
        send(32'h0000_4000, 32'd32, 2'd0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (meta_hs_cnt < cnt0 + 2 && n < 100);
        check("rst_mid_reached", 64'(meta_hs_cnt >= cnt0 + 2), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_addr.delete();
        exp_dp.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send(32'h0000_5003, 32'd9, 2'd2);
        drain();

        // Randomized transfers with random backpressure on both sides.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s = $urandom;
            if (i % 5 == 0) s = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            send(s, 32'($urandom_range(0, 40)), 2'($urandom_range(0, 3)));
            if (i % 8 == 7) drain();
        end
        drain();
        rand_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
